imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the CPU is the reader (combinational fetch via a/rd).
- Accepts a byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words, and writes them to sequential instruction-memory word addresses.
- Holds the CPU (cpu_hold) from reset until a load completes, so a program can be loaded at boot without a testbench-side memory initialisation.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-aligned.
- MAX_WORDS, 256, capacity in words; writes beyond it are suppressed.
- CNT_W, 9, width of words_loaded; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  in  1  rising-edge clock shared with CPU and memories
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load session
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_last  in  1  qualifies the final byte of the session; sampled with in_valid
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write enable
- mem_a  out  32  instruction-memory byte address, 4-aligned
- mem_wd  out  32  instruction-memory write data
- cpu_hold  out  1  1 = CPU must not advance the PC or commit state
- done  out  1  level; 1 after a session completes until the next start
- overflow  out  1  sticky per session; bytes arrived after MAX_WORDS words were written
- words_loaded  out  CNT_W  number of words written in the current or last session

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, mem_we=0, mem_a=0, mem_wd=0, cpu_hold=1, done=0, overflow=0, words_loaded=0, byte_idx=0, assembly register=0.
- States:
  - IDLE: cpu_hold=1, in_ready=0.
  - LOAD: cpu_hold=1, in_ready=1.
  - WRITE: cpu_hold=1, in_ready=0, mem_we=1.
  - DONE: cpu_hold=0, done=1, in_ready=0.
- start in IDLE or DONE -> LOAD next cycle. On the same edge: byte_idx=0, words_loaded=0, overflow=0, assembly register=0, done=0.
- start in LOAD or WRITE is ignored.
- Byte transfer: occurs on a rising edge with in_valid and in_ready both 1. The byte goes to bits [8*byte_idx+7 : 8*byte_idx], then byte_idx increments modulo 4.
- Word completion, from LOAD -> WRITE:
  - Trigger: the accepted byte has byte_idx=3, or has in_last=1.
  - Unfilled upper bytes of a partial word are 0.
  - The WRITE cycle lasts exactly one clock with mem_a = BASE_ADDR + 4*words_loaded and mem_wd = the assembled word.
  - The memory captures the write at the end of the WRITE cycle; words_loaded increments on that same edge.
  - Next state: DONE if the triggering byte had in_last=1, otherwise LOAD with the assembly register cleared.
- Throughput: 4 bytes take 4 LOAD cycles plus 1 WRITE cycle, i.e. 5 cycles per word at best.
- in_last with no partial word pending cannot occur; in_last always accompanies an accepted byte.
- Overflow (words_loaded == MAX_WORDS in LOAD):
  - Bytes are still accepted (in_ready=1) and discarded; no WRITE; overflow=1.
  - A byte with in_last=1 -> DONE.
  - words_loaded saturates at MAX_WORDS.
- mem_a and mem_wd hold their last values outside WRITE; mem_we=0 outside WRITE.
- Reset mid-session: everything returns to reset values immediately, including a mem_we asserted in WRITE. The partial word is lost and cpu_hold=1.
- All outputs are registered or decoded from state only; there is no combinational path from in_* to in_ready.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (out, 32): XOR of all mem_wd values written in the session.
  - It is cleared on start and on reset, and updates on the WRITE edge.
  - Adds input expect_sum (in, 32).
  - On entry to DONE, done is 1 only if checksum == expect_sum; otherwise state goes to IDLE (cpu_hold stays 1) and overflow is set as the error flag.
- When undefined: neither port exists, and DONE is entered unconditionally.

Test Plan:
- Reset value check: rst_n=0 for 2 cycles -> cpu_hold=1, in_ready=0, mem_we=0, done=0, words_loaded=0.
- Full word load:
  - Stimulus: start, then bytes 0x20,0x08,0x00,0x05 (last on 4th) with BASE_ADDR=0.
  - Required: exactly one mem_we pulse with mem_a=0, mem_wd=32'h0500_0820; then done=1, cpu_hold=0, words_loaded=1; instruction memory word 0 reads 32'h0500_0820.
- Partial word:
  - Stimulus: bytes 0xAA,0xBB,0xCC,0xDD,0x11,0x22(last).
  - Required: writes 32'hDDCC_BBAA @0 and 32'h0000_2211 @4; words_loaded=2.
- Backpressure: drop in_valid randomly during the session -> same memory contents; in_ready=0 in every WRITE cycle; no byte duplicated or lost.
- Overflow:
  - Stimulus: MAX_WORDS=2, stream 12 bytes (last on 12th).
  - Required: only addresses 0 and 4 written; overflow=1; words_loaded=2; done=1.
- Reset mid-session: assert rst_n=0 during the WRITE cycle of word 1 -> mem_we drops immediately, cpu_hold=1, state IDLE; a new start reloads from BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream into little-endian words written to instruction memory, holding the CPU until done.
// Define IMEM_LOADER_CHECKSUM_EN to add checksum/expect_sum verification of the loaded image.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256,
   parameter int          CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             mem_we,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   output logic             cpu_hold,
   output logic             done,
   output logic             overflow,
`ifdef IMEM_LOADER_CHECKSUM_EN
   output logic [31:0]      checksum,
   input  logic [31:0]      expect_sum,
`endif
   output logic [CNT_W-1:0] words_loaded
);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WRITE = 2'd2, DONE = 2'd3;
   logic [1:0]       state_q, state_d, byte_idx_q, byte_idx_d;
   logic [31:0]      asm_q, asm_d, mem_a_q, mem_a_d, mem_wd_q, mem_wd_d, word;
   logic             last_q, last_d, ovf_q, ovf_d, full, restart, sum_ok;
   logic [CNT_W-1:0] words_q, words_d;
   assign restart = start && (state_q == IDLE || state_q == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
   // Compare against the sum including a write landing on this same edge.
   assign sum_ok = ((state_q == WRITE) ? (sum_q ^ mem_wd_q) : sum_q) == expect_sum;
   assign sum_d = restart ? 32'd0 : (state_q == WRITE) ? (sum_q ^ mem_wd_q) : sum_q;
   assign checksum = sum_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= 32'd0;
      else        sum_q <= sum_d;
   end
`else
   assign sum_ok = 1'b1;
`endif
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      mem_a_d    = mem_a_q;
      mem_wd_d   = mem_wd_q;
      last_d     = last_q;
      ovf_d      = ovf_q;
      words_d    = words_q;
      word       = asm_q | (32'(in_data) << {byte_idx_q, 3'b000});
      full       = words_q == CNT_W'(MAX_WORDS);
      if (restart) begin
         state_d    = LOAD;
         byte_idx_d = 2'd0;
         asm_d      = 32'd0;
         words_d    = '0;
         ovf_d      = 1'b0;
      end else if (state_q == LOAD && in_valid) begin
         byte_idx_d = byte_idx_q + 2'd1;
         if (full) begin
            ovf_d = 1'b1;
            if (in_last) state_d = sum_ok ? DONE : IDLE;
         end else if (byte_idx_q == 2'd3 || in_last) begin
            state_d  = WRITE;
            asm_d    = 32'd0;
            mem_a_d  = BASE_ADDR + (32'(words_q) << 2);
            mem_wd_d = word;
            last_d   = in_last;
         end else begin
            asm_d = word;
         end
      end else if (state_q == WRITE) begin
         words_d = words_q + 1'b1;
         state_d = !last_q ? LOAD : sum_ok ? DONE : IDLE;
         ovf_d   = ovf_q | (last_q & !sum_ok);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         byte_idx_q <= 2'd0;
         asm_q      <= 32'd0;
         mem_a_q    <= 32'd0;
         mem_wd_q   <= 32'd0;
         last_q     <= 1'b0;
         ovf_q      <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         mem_a_q    <= mem_a_d;
         mem_wd_q   <= mem_wd_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
         words_q    <= words_d;
      end
   end
   assign in_ready     = state_q == LOAD;
   assign mem_we       = state_q == WRITE;
   assign cpu_hold     = state_q != DONE;
   assign done         = state_q == DONE;
   assign mem_a        = mem_a_q;
   assign mem_wd       = mem_wd_q;
   assign overflow     = ovf_q;
   assign words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random byte sessions with backpressure checked against a word-packing model and a shadow instruction memory.
module tb_imem_loader;
   localparam int MAXW = 2;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready, mem_we, cpu_hold, done, overflow;
   logic [31:0] mem_a, mem_wd;
   logic [8:0]  words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] checksum, expect_sum = 32'd0;
`endif
   int          n_checks = 0, n_fail = 0;
   logic [31:0] wr_a[$], wr_d[$];
   logic [31:0] imem [0:MAXW-1];

   imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAXW), .CNT_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
      .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .checksum(checksum), .expect_sum(expect_sum),
`endif
      .words_loaded(words_loaded));

   always #5 clk = ~clk;

   // Shadow memory captures writes at the end of the WRITE cycle.
   always @(posedge clk) begin
      if (mem_we) begin
         wr_a.push_back(mem_a);
         wr_d.push_back(mem_wd);
         if (int'(mem_a >> 2) < MAXW) imem[int'(mem_a >> 2)] = mem_wd;
         n_checks++;
         if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL write_cycle: in_ready=%b cpu_hold=%b, required 0/1", in_ready, cpu_hold);
         end
      end
   end

   task automatic run_session(input logic [7:0] b[$], input int drop, input string tag);
      int n = b.size();
      int nw = (n + 3) / 4;
      logic [31:0] ew[$];
      logic exp_ovf = nw > MAXW;
      logic rdy, acc;
      logic [31:0] xs = 32'd0;
      for (int w = 0; w < nw && w < MAXW; w++) begin
         logic [31:0] v = 32'd0;
         for (int k = 0; k < 4; k++) if (4*w + k < n) v |= 32'(b[4*w + k]) << (8*k);
         ew.push_back(v);
         xs ^= v;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      expect_sum = xs;
`endif
      wr_a.delete();
      wr_d.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         acc = 1'b0;
         while (!acc) begin
            in_valid = $urandom_range(0, 99) >= drop;
            in_data  = b[i];
            in_last  = i == n - 1;
            rdy = in_ready;
            @(posedge clk);
            acc = in_valid && rdy;
            @(negedge clk);
            if (++guard > 60) begin
               n_checks++; n_fail++;
               $display("FAIL %s byte_timeout: byte %0d not accepted, required acceptance", tag, i);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int c = 0; c < 10 && !done; c++) @(negedge clk);
      n_checks += 5;
      if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %b required 1", tag, done); end
      if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL %s cpu_hold: got %b required 0", tag, cpu_hold); end
      if (words_loaded !== 9'(ew.size())) begin n_fail++; $display("FAIL %s words_loaded: got %0d required %0d", tag, words_loaded, ew.size()); end
      if (overflow !== exp_ovf) begin n_fail++; $display("FAIL %s overflow: got %b required %b", tag, overflow, exp_ovf); end
      if (wr_a.size() != ew.size()) begin n_fail++; $display("FAIL %s write_count: got %0d required %0d", tag, wr_a.size(), ew.size()); end
      for (int j = 0; j < ew.size() && j < wr_a.size(); j++) begin
         n_checks += 3;
         if (wr_a[j] !== 32'(4*j)) begin n_fail++; $display("FAIL %s addr[%0d]: got %h required %h", tag, j, wr_a[j], 32'(4*j)); end
         if (wr_d[j] !== ew[j]) begin n_fail++; $display("FAIL %s data[%0d]: got %h required %h", tag, j, wr_d[j], ew[j]); end
         if (imem[j] !== ew[j]) begin n_fail++; $display("FAIL %s imem[%0d]: got %h required %h", tag, j, imem[j], ew[j]); end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      n_checks++;
      if (checksum !== xs) begin n_fail++; $display("FAIL %s checksum: got %h required %h", tag, checksum, xs); end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks += 6;
      if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset cpu_hold: got %b required 1", cpu_hold); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b required 0", in_ready); end
      if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we: got %b required 0", mem_we); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b required 0", done); end
      if (words_loaded !== 9'd0) begin n_fail++; $display("FAIL reset words_loaded: got %0d required 0", words_loaded); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %b required 0", overflow); end
      rst_n = 1'b1;
   endtask

   task automatic test_full_word();
      logic [7:0] q[$];
      q = {8'h20, 8'h08, 8'h00, 8'h05};
      run_session(q, 0, "full_word");
      n_checks++;
      if (imem[0] !== 32'h0500_0820) begin n_fail++; $display("FAIL full_word imem0: got %h required 05000820", imem[0]); end
   endtask

   task automatic test_partial();
      logic [7:0] q[$];
      q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      run_session(q, 0, "partial");
      n_checks += 2;
      if (imem[0] !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL partial imem0: got %h required ddccbbaa", imem[0]); end
      if (imem[1] !== 32'h0000_2211) begin n_fail++; $display("FAIL partial imem1: got %h required 00002211", imem[1]); end
   endtask

   task automatic test_backpressure();
      logic [7:0] q[$];
      q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      for (int r = 0; r < 4; r++) run_session(q, 50, "backpressure");
   endtask

   task automatic test_overflow();
      logic [7:0] q[$];
      for (int i = 0; i < 12; i++) q.push_back(8'(8'h30 + i));
      run_session(q, 30, "overflow");
   endtask

   task automatic test_back_to_back();
      for (int s = 0; s < 16; s++) begin
         logic [7:0] q[$];
         int n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         run_session(q, $urandom_range(0, 60), "random");
      end
   endtask

   task automatic test_reset_mid();
      logic rdy;
      int i = 0;
      bit hit = 0;
      wr_a.delete();
      wr_d.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         if (mem_we && mem_a == 32'd4) hit = 1;
         else begin
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + i);
            in_last  = i == 7;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) i++;
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL reset_mid reach_write1: got no write at 4, required one"); end
      #1 rst_n = 1'b0;
      #1;
      n_checks += 5;
      if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mid mem_we: got %b required 0", mem_we); end
      if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_mid cpu_hold: got %b required 1", cpu_hold); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid in_ready: got %b required 0", in_ready); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid done: got %b required 0", done); end
      if (words_loaded !== 9'd0) begin n_fail++; $display("FAIL reset_mid words_loaded: got %0d required 0", words_loaded); end
      @(negedge clk) rst_n = 1'b1;
      begin
         logic [7:0] q[$];
         q = {8'h13, 8'h57, 8'h9B, 8'hDF};
         run_session(q, 20, "reset_mid_reload");
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
